button_event: RTL
=================

BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the internal interval counter.
REQ-002 SHALL have parameter HOLD_DELAY, default 2500: cycles from press_pulse to first repeat (0.5 s at 5 kHz); legal 2..2^CNT_W-1.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 500: cycles between repeat pulses (0.1 s at 5 kHz); legal 1..2^CNT_W-1.
REQ-004 SHALL have parameter REPEAT_EN, default 1: 0 suppresses repeat_pulse; long_press is unaffected.
REQ-005 SHALL have port clk, input, 1: single clock (5 kHz domain); all logic on posedge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port button_level, input, 1: already-debounced, clk-synchronous button level.
REQ-008 SHALL have port press_pulse, output, 1: one-cycle strobe on press.
REQ-009 SHALL have port release_pulse, output, 1: one-cycle strobe on release.
REQ-010 SHALL have port repeat_pulse, output, 1: one-cycle strobe per auto-repeat.
REQ-011 SHALL have port action_pulse, output, 1: press_pulse OR repeat_pulse, for push/pop consumers.
REQ-012 SHALL have port held, output, 1: high while the FSM is in WAIT_HOLD or REPEAT.
REQ-013 SHALL have port long_press, output, 1: high once the hold exceeds HOLD_DELAY, until release.

Function
REQ-014 SHALL register all outputs; no combinational path from button_level to any output.
REQ-015 SHALL keep prev_level, the button_level sampled on the previous edge.
REQ-016 SHALL implement FSM states IDLE, WAIT_HOLD, REPEAT.
REQ-017 IDLE: on an edge where button_level=1 and prev_level=0, SHALL assert press_pulse for the next cycle only, clear the counter and go to WAIT_HOLD (latency 1 cycle).
REQ-018 WAIT_HOLD: counter SHALL increment each cycle; when the count reaches HOLD_DELAY-1 with button_level=1, the FSM SHALL enter REPEAT and clear the counter. long_press SHALL rise and repeat_pulse (if REPEAT_EN) SHALL assert, both exactly HOLD_DELAY cycles after press_pulse.
REQ-019 REPEAT: counter SHALL increment each cycle and wrap to 0 at REPEAT_PERIOD-1; each wrap SHALL assert repeat_pulse (if REPEAT_EN), i.e. every REPEAT_PERIOD cycles.
REQ-020 In WAIT_HOLD or REPEAT, an edge with button_level=0 SHALL assert release_pulse for one cycle, clear the counter and long_press, deassert held, and return to IDLE.
REQ-021 A release coinciding with a hold-expiry or repeat-wrap edge SHALL take priority: release_pulse only, no repeat_pulse, long_press not set.
REQ-022 A one-cycle high button_level SHALL yield press_pulse and release_pulse on consecutive cycles.
REQ-023 The counter SHALL never exceed max(HOLD_DELAY, REPEAT_PERIOD)-1 and SHALL never overflow CNT_W.
REQ-024 press_pulse, release_pulse and repeat_pulse SHALL be mutually exclusive in any cycle.

Reset
REQ-025 While reset=1 at an edge: state IDLE, counter 0, prev_level 0, all outputs 0.
REQ-026 Reset mid-hold SHALL abort the hold with no release_pulse; if button_level=1 on the first edge after reset deasserts, a fresh press_pulse SHALL follow.
REQ-027 Reset SHALL take priority over all other transitions.

Structure
REQ-028 The FSM state encoding and default timing constants SHALL live in shared package button_pkg.
REQ-029 The block SHALL be a single module without sub-modules; it is instantiated downstream of the debouncer by its parent.

Verification (HOLD_DELAY=4, REPEAT_PERIOD=2, REPEAT_EN=1)
REQ-030 Hold button_level=1 for 3 cycles -> press_pulse 1 cycle after rise, release_pulse 1 cycle after fall, no repeat_pulse, long_press stays 0.
REQ-031 Hold 11 cycles -> repeat_pulse at press+4, +6, +8, +10; long_press high from press+4 until release; action_pulse = 5 strobes total.
REQ-032 Release on the exact hold-expiry edge -> release_pulse only, long_press never set.
REQ-033 Single-cycle high pulse -> press_pulse and release_pulse on consecutive cycles, held high for 1 cycle.
REQ-034 Assert reset at press+5 with button still held, release reset next cycle -> outputs 0 during reset, no release_pulse, new press_pulse 1 cycle after reset drops.
REQ-035 REPEAT_EN=0, hold 11 cycles -> no repeat_pulse, long_press at press+4, one action_pulse.

Source files
------------

// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : button_pkg
//  Description : Shared definitions for the button event block: FSM state
//                encoding and default timing constants (5 kHz clock domain).
//  Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

    // Explicit 2-bit encoding; 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_WAIT_HOLD = 2'b01,
        ST_REPEAT    = 2'b10
    } state_t;

    localparam int c_default_cnt_w         = 16;
    localparam int c_default_hold_delay    = 2500;  // 0.5 s at 5 kHz
    localparam int c_default_repeat_period = 500;   // 0.1 s at 5 kHz

endpackage : button_pkg
`default_nettype wire

// File: rtl/button_event.sv
`default_nettype none
// ============================================================================
//  Module      : button_event
//  Description : Turns a debounced, clk-synchronous button level into press,
//                release and auto-repeat strobes plus held / long-press flags.
//                All outputs are registered.
//  Ports       : clk           - single clock, posedge
//                reset         - synchronous, active-high
//                button_level  - debounced button level
//                press_pulse   - one-cycle strobe on press
//                release_pulse - one-cycle strobe on release
//                repeat_pulse  - one-cycle strobe per auto-repeat
//                action_pulse  - press_pulse OR repeat_pulse
//                held          - high while in WAIT_HOLD or REPEAT
//                long_press    - high once hold exceeds HOLD_DELAY, until release
//  Revision    : 1.0 - initial release
// ============================================================================
module button_event
    import button_pkg::*;
#(
    parameter int CNT_W         = c_default_cnt_w,
    parameter int HOLD_DELAY    = c_default_hold_delay,
    parameter int REPEAT_PERIOD = c_default_repeat_period,
    parameter bit REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic button_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic action_pulse,
    output logic held,
    output logic long_press
);

    // Terminal counts: the counter is compared against these, so it never
    // climbs past max(HOLD_DELAY, REPEAT_PERIOD)-1.
    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(HOLD_DELAY - 1);
    localparam logic [CNT_W-1:0] c_rep_last  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_prev_level;
    logic             r_press;
    logic             r_release;
    logic             r_repeat;
    logic             r_action;
    logic             r_held;
    logic             r_long;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_prev_level <= 1'b0;
            r_press      <= 1'b0;
            r_release    <= 1'b0;
            r_repeat     <= 1'b0;
            r_action     <= 1'b0;
            r_held       <= 1'b0;
            r_long       <= 1'b0;
        end else begin
            r_prev_level <= button_level;
            // Strobes default low so each lasts exactly one cycle.
            r_press      <= 1'b0;
            r_release    <= 1'b0;
            r_repeat     <= 1'b0;
            r_action     <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // Rising edge only: a level still high after reset with
                    // prev_level cleared also counts as a fresh press.
                    if (button_level && !r_prev_level) begin
                        r_press  <= 1'b1;
                        r_action <= 1'b1;
                        r_cnt    <= '0;
                        r_held   <= 1'b1;
                        r_state  <= ST_WAIT_HOLD;
                    end
                end

                ST_WAIT_HOLD: begin
                    // Release is tested first so it wins over hold expiry.
                    if (!button_level) begin
                        r_release <= 1'b1;
                        r_cnt     <= '0;
                        r_long    <= 1'b0;
                        r_held    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (r_cnt == c_hold_last) begin
                        r_cnt    <= '0;
                        r_long   <= 1'b1;
                        r_repeat <= REPEAT_EN;
                        r_action <= REPEAT_EN;
                        r_state  <= ST_REPEAT;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end

                ST_REPEAT: begin
                    if (!button_level) begin
                        r_release <= 1'b1;
                        r_cnt     <= '0;
                        r_long    <= 1'b0;
                        r_held    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (r_cnt == c_rep_last) begin
                        r_cnt    <= '0;
                        r_repeat <= REPEAT_EN;
                        r_action <= REPEAT_EN;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end

                default: begin
                    r_cnt   <= '0;
                    r_held  <= 1'b0;
                    r_long  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign repeat_pulse  = r_repeat;
    assign action_pulse  = r_action;
    assign held          = r_held;
    assign long_press    = r_long;

endmodule : button_event
`default_nettype wire
